dmem_lsu: RTL and testbench
===========================

// Module: dmem_lsu
// PURPOSE
//  Load/store unit directly upstream of dmem. Accepts one CPU memory request at a time and drives the dmem mem_port.
//  Supports LB/LH/LW/LBU/LHU/SB/SH/SW. Sub-word stores are read-modify-write, because dmem writes all 4 byte lanes.
//  Load data is sign- or zero-extended before return. Misaligned and illegal requests get an error response.
// PARAMETERS
//  ADDR_WIDTH  pkg_parameters::DMEM_ADDR_WIDTH  byte address width on the CPU side and the memory side
//  XLEN        32                               data width; only 32 is legal (elaboration $error otherwise)
// PORTS
//  clk         in   1           clock; all state changes on posedge
//  rst_n       in   1           asynchronous, active-low reset
//  req_valid   in   1           CPU request present
//  req_ready   out  1           LSU can accept (state==IDLE)
//  req_we      in   1           1=store, 0=load
//  req_funct3  in   3           RV32I funct3 (load 000/001/010/100/101; store 000/001/010)
//  req_addr    in   ADDR_WIDTH  byte address
//  req_wdata   in   XLEN        store data; the low bytes are used for SB/SH
//  resp_valid  out  1           one-cycle pulse; response complete; no backpressure
//  resp_rdata  out  XLEN        extended load data; 0 for stores and errors
//  resp_err    out  1           request was misaligned or had an illegal funct3
//  mem_ena     out  1           dmem enable
//  mem_web     out  1           dmem write enable (active-high)
//  mem_addr    out  ADDR_WIDTH  dmem byte address, always word-aligned ({addr[AW-1:2],2'b00})
//  mem_din     out  XLEN        dmem write data; lane i = bits[8i+7:8i] -> byte base+i
//  mem_dout    in   XLEN        dmem read data, valid the cycle after mem_ena with mem_web=0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0; internal regs cleared.
//   mem_* outputs are 0 immediately (combinational from state). An in-flight RMW is dropped; no partial write occurs.
//  FSM states: IDLE, LD_WAIT, RMW_RD, RMW_WR.
//   A request is accepted when req_valid & req_ready. Accept cycle = T. Request fields are latched at T.
//  Error check at T:
//   LH/LHU/SH require addr[0]=0. LW/SW require addr[1:0]=0. Illegal funct3 is an error.
//   On error: no memory access; resp_valid=1 and resp_err=1 at T+1; state stays IDLE.
//  SW:  at T, mem_ena=1, mem_web=1, mem_din=req_wdata (combinational). resp_valid at T+1. Stays IDLE.
//  Load: at T, mem_ena=1, mem_web=0; go to LD_WAIT. At T+1, extract the lane from mem_dout using the latched addr[1:0].
//   Extension: LB/LH sign-extend; LBU/LHU zero-extend.
//   resp_rdata is registered; resp_valid at T+2; return to IDLE on the T+1 edge.
//  SB/SH: at T, read word (mem_web=0); go to RMW_RD. At T+1, merge wdata into mem_dout at lane addr[1:0] (SB) or addr[1] (SH).
//   Hold the merged word in a register; go to RMW_WR.
//   At T+2, mem_ena=1, mem_web=1, mem_din=merged. resp_valid at T+3; go to IDLE.
//  mem_* outputs are 0 in any cycle with no access. req_ready=0 outside IDLE.
//  Back-to-back: a new request may be accepted in the same cycle its predecessor's resp_valid is high.
//  resp_valid is exactly one cycle wide. resp_rdata/resp_err hold until the next response or reset.
//  Address arithmetic wraps modulo 2^ADDR_WIDTH. No range check; dmem depth is the owner's concern.
//  Little-endian: byte at addr+k lives in lane k of the word at base.
// TESTING
//  1 SW 0x0000_0010 <- 0xDEADBEEF, then LW 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 2 cycles after load accept.
//  2 After test 1: SB 0x12 <- 0x55, then LW 0x10 -> 0xDE55BEEF. SB resp 3 cycles after accept; exactly one mem_web=1 cycle.
//  3 After test 1: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
//  4 LW 0x11 / SH 0x13 / funct3=011 load -> resp_err=1, resp_rdata=0, mem_ena never asserted; memory unchanged (LW 0x10 still 0xDEADBEEF).
//  5 Issue SH 0x10 <- 0x1234; pull rst_n low while in RMW_WR -> mem_ena drops at once; after reset, resp_valid=0, req_ready=1, LW 0x10 -> 0xDEADBEEF.
//  6 Back-to-back stream LW,SW,LB with req_valid held high -> each accept coincides with the prior resp_valid; no request dropped.

Source files
------------

// File: rtl/dmem_lsu.sv
// Load/store unit in front of a word-wide dmem: handles one request at a time,
// extends load data and performs sub-word stores as read-modify-write.
module dmem_lsu #(
  parameter int ADDR_WIDTH = 16,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_err,
  output logic                  mem_ena,
  output logic                  mem_web,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_din,
  input  logic [XLEN-1:0]       mem_dout
);

  if (XLEN != 32) begin : g_xlen_check
    $error("dmem_lsu: XLEN must be 32");
  end

  typedef enum logic [1:0] {IDLE, LD_WAIT, RMW_RD, RMW_WR} state_t;

  state_t                  state, state_nxt;
  logic                    accept, req_err, is_sw;
  logic [2:0]              funct3_p1;
  logic [ADDR_WIDTH-1:0]   addr_p1;
  logic [XLEN-1:0]         wdata_p1;
  logic [XLEN-1:0]         merged_p2;

  function automatic logic check_err(input logic we, input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      3'b000:  return 1'b0;
      3'b001:  return lo[0];
      3'b010:  return |lo;
      3'b100:  return we;
      3'b101:  return we | lo[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] merge_store(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] word, input logic [31:0] wd);
    logic [31:0] m;
    m = word;
    if (f3[1:0] == 2'b00) m[{lo, 3'b000} +: 8] = wd[7:0];
    else if (lo[1])       m[31:16] = wd[15:0];
    else                  m[15:0]  = wd[15:0];
    return m;
  endfunction

  assign req_ready = (state == IDLE);
  // Gating with rst_n keeps every mem_* output low for the whole reset window.
  assign accept    = req_valid & req_ready & rst_n;
  assign req_err   = check_err(req_we, req_funct3, req_addr[1:0]);
  assign is_sw     = req_we & (req_funct3 == 3'b010);

  always_comb begin
    state_nxt = state;
    mem_ena   = 1'b0;
    mem_web   = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    case (state)
      IDLE: begin
        if (accept && !req_err) begin
          mem_ena  = 1'b1;
          mem_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          if (is_sw) begin
            mem_web = 1'b1;
            mem_din = req_wdata;
          end else if (req_we) begin
            state_nxt = RMW_RD;
          end else begin
            state_nxt = LD_WAIT;
          end
        end
      end
      LD_WAIT: state_nxt = IDLE;
      RMW_RD:  state_nxt = RMW_WR;
      RMW_WR: begin
        mem_ena   = 1'b1;
        mem_web   = 1'b1;
        mem_addr  = {addr_p1[ADDR_WIDTH-1:2], 2'b00};
        mem_din   = merged_p2;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      funct3_p1  <= '0;
      addr_p1    <= '0;
      wdata_p1   <= '0;
      merged_p2  <= '0;
    end else begin
      state      <= state_nxt;
      resp_valid <= 1'b0;
      // stage p0 -> p1: latch request; errors and SW answer immediately
      if (accept) begin
        funct3_p1 <= req_funct3;
        addr_p1   <= req_addr;
        wdata_p1  <= req_wdata;
        if (req_err || is_sw) begin
          resp_valid <= 1'b1;
          resp_err   <= req_err;
          resp_rdata <= '0;
        end
      end
      // stage p1 -> p2: load return, or merge for the sub-word write
      case (state)
        LD_WAIT: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= extend_load(funct3_p1, addr_p1[1:0], mem_dout);
        end
        RMW_RD: merged_p2 <= merge_store(funct3_p1, addr_p1[1:0], mem_dout, wdata_p1);
        RMW_WR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a small behavioural dmem model attached.
module tb_dmem_lsu;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid, resp_err;
  logic [31:0]   resp_rdata;
  logic          mem_ena, mem_web;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_WIDTH(AW), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_ena(mem_ena), .mem_web(mem_web), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // dmem model: synchronous write of a full word, registered read
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (mem_ena) begin
      if (mem_web) mem[mem_addr[7:2]] <= mem_din;
      else         mem_dout <= mem[mem_addr[7:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Entered and left at posedge+1; reports latency in cycles from accept to resp_valid.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output int nwr, output int nena);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    check("ready_at_accept", 32'(req_ready), 32'd1);
    nena = int'(mem_ena);
    nwr  = int'(mem_ena & mem_web);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    rd = '0; er = 1'b0;
    while (lat < 10) begin
      @(negedge clk);
      nena += int'(mem_ena);
      nwr  += int'(mem_ena & mem_web);
      if (resp_valid) begin
        rd = resp_rdata; er = resp_err;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, nwr, nena;

  task automatic load_expect(input string tag, input logic [2:0] f3, input logic [AW-1:0] a,
                             input logic [31:0] exp);
    logic [31:0] r; logic e; int l, w, n;
    do_req(1'b0, f3, a, 32'd0, r, e, l, w, n);
    check({tag, "_data"}, r, exp);
    check({tag, "_err"}, 32'(e), 32'd0);
    check({tag, "_lat"}, 32'(l), 32'd2);
  endtask

  int          acc [3];
  int          rsp [3];
  logic [31:0] rdat [3];
  logic        b2b_we [3];
  logic [2:0]  b2b_f3 [3];
  logic [15:0] b2b_a [3];
  logic [31:0] b2b_wd [3];

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_mem_ena", 32'(mem_ena), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: SW then LW
    do_req(1'b1, 3'b010, 16'h0010, 32'hDEADBEEF, rd, er, lat, nwr, nena);
    check("sw_lat", 32'(lat), 32'd1);
    check("sw_err", 32'(er), 32'd0);
    check("sw_rdata", rd, 32'd0);
    check("sw_writes", 32'(nwr), 32'd1);
    load_expect("lw10", 3'b010, 16'h0010, 32'hDEADBEEF);

    // 2: SB read-modify-write
    do_req(1'b1, 3'b000, 16'h0012, 32'h00000055, rd, er, lat, nwr, nena);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_writes", 32'(nwr), 32'd1);
    check("sb_err", 32'(er), 32'd0);
    load_expect("lw_after_sb", 3'b010, 16'h0010, 32'hDE55BEEF);
    do_req(1'b1, 3'b010, 16'h0010, 32'hDEADBEEF, rd, er, lat, nwr, nena);

    // 3: sub-word loads with extension
    load_expect("lb13", 3'b000, 16'h0013, 32'hFFFFFFDE);
    load_expect("lbu13", 3'b100, 16'h0013, 32'h000000DE);
    load_expect("lh10", 3'b001, 16'h0010, 32'hFFFFBEEF);
    load_expect("lhu12", 3'b101, 16'h0012, 32'h0000DEAD);

    // 4: misaligned and illegal requests
    do_req(1'b0, 3'b010, 16'h0011, 32'd0, rd, er, lat, nwr, nena);
    check("lw11_err", 32'(er), 32'd1);
    check("lw11_rdata", rd, 32'd0);
    check("lw11_ena", 32'(nena), 32'd0);
    check("lw11_lat", 32'(lat), 32'd1);
    do_req(1'b1, 3'b001, 16'h0013, 32'h0000AAAA, rd, er, lat, nwr, nena);
    check("sh13_err", 32'(er), 32'd1);
    check("sh13_ena", 32'(nena), 32'd0);
    do_req(1'b0, 3'b011, 16'h0010, 32'd0, rd, er, lat, nwr, nena);
    check("f3_011_err", 32'(er), 32'd1);
    check("f3_011_rdata", rd, 32'd0);
    check("f3_011_ena", 32'(nena), 32'd0);
    load_expect("lw_after_err", 3'b010, 16'h0010, 32'hDEADBEEF);

    // 5: reset during the write phase of an SH
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 16'h0010;
    req_wdata = 32'h00001234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rmw_wr_ena", 32'(mem_ena), 32'd1);
    check("rmw_wr_web", 32'(mem_web), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_drop_ena", 32'(mem_ena), 32'd0);
    check("rst_drop_web", 32'(mem_web), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", 32'(resp_valid), 32'd0);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    load_expect("lw_after_rst", 3'b010, 16'h0010, 32'hDEADBEEF);

    // 6: back-to-back LW, SW, LB with req_valid held high
    b2b_we = '{1'b0, 1'b1, 1'b0};
    b2b_f3 = '{3'b010, 3'b010, 3'b000};
    b2b_a  = '{16'h0010, 16'h0020, 16'h0013};
    b2b_wd = '{32'd0, 32'hCAFEF00D, 32'd0};
    for (int i = 0; i < 3; i++) begin
      acc[i] = -1; rsp[i] = -2; rdat[i] = 32'hXXXXXXXX;
    end
    begin
      int cyc, idx, ridx;
      logic took;
      cyc = 0; idx = 0; ridx = 0;
      req_valid = 1'b1; req_we = b2b_we[0]; req_funct3 = b2b_f3[0];
      req_addr = b2b_a[0]; req_wdata = b2b_wd[0];
      while (ridx < 3 && cyc < 20) begin
        @(negedge clk);
        took = req_valid & req_ready;
        if (took) begin
          acc[idx] = cyc;
          idx++;
        end
        if (resp_valid) begin
          rsp[ridx] = cyc; rdat[ridx] = resp_rdata;
          ridx++;
        end
        @(posedge clk); #1;
        if (took) begin
          if (idx < 3) begin
            req_we = b2b_we[idx]; req_funct3 = b2b_f3[idx];
            req_addr = b2b_a[idx]; req_wdata = b2b_wd[idx];
          end else begin
            req_valid = 1'b0;
          end
        end
        cyc++;
      end
      req_valid = 1'b0;
      check("b2b_resp_count", 32'(ridx), 32'd3);
    end
    check("b2b_accept1", 32'(acc[1]), 32'(rsp[0]));
    check("b2b_accept2", 32'(acc[2]), 32'(rsp[1]));
    check("b2b_lw_lat", 32'(rsp[0] - acc[0]), 32'd2);
    check("b2b_lw_data", rdat[0], 32'hDEADBEEF);
    check("b2b_sw_data", rdat[1], 32'd0);
    check("b2b_lb_data", rdat[2], 32'hFFFFFFDE);
    @(posedge clk); #1;
    load_expect("lw20", 3'b010, 16'h0020, 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
